// File: rtl/lfsr_delay_pkg.sv
// Shared types for the LFSR-driven hold-off timer.
package lfsr_delay_pkg;

  localparam int SEED_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    FIRE
  } delay_state_t;

endpackage

// File: rtl/lfsr_delay_timer.sv
// Random hold-off timer: captures an LFSR seed, counts it down on tick pulses, pulses time_out.
// Optional abort input is built in when DELAY_ABORT_EN is defined.
module lfsr_delay_timer
  import lfsr_delay_pkg::*;
#(
  parameter int D_WIDTH   = SEED_W,
  parameter int MIN_TICKS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               trigger,
  input  logic [D_WIDTH-1:0] seed,
`ifdef DELAY_ABORT_EN
  input  logic               abort,
`endif
  output logic               lfsr_adv,
  output logic               busy,
  output logic               time_out,
  output logic [D_WIDTH-1:0] count_out
);

  localparam logic [D_WIDTH-1:0] MIN_CNT = D_WIDTH'(MIN_TICKS);
  localparam logic [D_WIDTH-1:0] ONE_CNT = D_WIDTH'(1);

  if (MIN_TICKS < 1 || MIN_TICKS > (2 ** D_WIDTH) - 1) begin : g_min_ticks_check
    $error("lfsr_delay_timer: MIN_TICKS must lie in 1 .. 2**D_WIDTH-1");
  end

  delay_state_t       state_q, state_d;
  logic [D_WIDTH-1:0] count_q, count_d;
  logic               lfsr_adv_q, lfsr_adv_d;
  logic               busy_q, busy_d;
  logic               time_out_q, time_out_d;
  logic               abort_req;

`ifdef DELAY_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // A zero seed is the LFSR lock-up value, so the floor also guarantees a non-empty delay.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    lfsr_adv_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          count_d    = (seed < MIN_CNT) ? MIN_CNT : seed;
          lfsr_adv_d = 1'b1;
          state_d    = COUNT;
        end
      end
      COUNT: begin
        if (abort_req) begin
          count_d = '0;
          state_d = IDLE;
        end else if (tick) begin
          if (count_q > ONE_CNT) begin
            count_d = count_q - ONE_CNT;
          end else begin
            count_d = '0;
            state_d = FIRE;
          end
        end
      end
      FIRE: begin
        state_d = IDLE;
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
    busy_d     = (state_d != IDLE);
    time_out_d = (state_q == FIRE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      lfsr_adv_q <= 1'b0;
      busy_q     <= 1'b0;
      time_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      lfsr_adv_q <= lfsr_adv_d;
      busy_q     <= busy_d;
      time_out_q <= time_out_d;
    end
  end

  assign lfsr_adv  = lfsr_adv_q;
  assign busy      = busy_q;
  assign time_out  = time_out_q;
  assign count_out = count_q;

endmodule

// File: tb/tb_lfsr_delay_timer.sv
// Bench for lfsr_delay_timer (MIN_TICKS=3); covers the abort path when DELAY_ABORT_EN is defined.
module tb_lfsr_delay_timer;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       trigger;
  logic [6:0] seed;
  logic       lfsr_adv;
  logic       busy;
  logic       time_out;
  logic [6:0] count_out;
`ifdef DELAY_ABORT_EN
  logic       abort;
`endif

  typedef struct {
    bit is_tout;
    int value;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  adv_cyc = 0;

  lfsr_delay_timer #(.D_WIDTH(7), .MIN_TICKS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .trigger   (trigger),
    .seed      (seed),
`ifdef DELAY_ABORT_EN
    .abort     (abort),
`endif
    .lfsr_adv  (lfsr_adv),
    .busy      (busy),
    .time_out  (time_out),
    .count_out (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every lfsr_adv or time_out pulse must match the next queued event.
  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      if (lfsr_adv) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL spurious_adv: got lfsr_adv=1 count_out=%0d, required no pulse", count_out);
        end else begin
          e = exp_q.pop_front();
          if (e.is_tout || count_out !== 7'(e.value)) begin
            errors++;
            $display("[TB] FAIL adv_capture: got adv with count_out=%0d, required %s %0d",
                     count_out, e.is_tout ? "time_out after" : "adv with count", e.value);
          end
        end
        adv_cyc = cyc;
      end
      if (time_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL spurious_time_out: got time_out=1 at cycle %0d, required no pulse", cyc);
        end else begin
          e = exp_q.pop_front();
          if (!e.is_tout || (cyc - adv_cyc) != e.value) begin
            errors++;
            $display("[TB] FAIL time_out_latency: got time_out %0d cycles after adv, required %s %0d",
                     cyc - adv_cyc, e.is_tout ? "latency" : "adv with count", e.value);
          end
        end
      end
    end
  end

  task automatic push_ev(input bit is_tout, input int value);
    ev_t e;
    e.is_tout = is_tout;
    e.value   = value;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic trg, input logic tk);
    trigger = trg;
    tick    = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  initial begin
    rst     = 1'b0;
    trigger = 1'b1;
    tick    = 1'b1;
    seed    = 7'd5;
`ifdef DELAY_ABORT_EN
    abort   = 1'b0;
`endif

    // Reset held with trigger and tick active: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_output("reset_busy", busy, 0);
      check_output("reset_time_out", time_out, 0);
      check_output("reset_lfsr_adv", lfsr_adv, 0);
      check_output("reset_count", count_out, 0);
    end
    trigger = 1'b0;
    rst     = 1'b1;
    apply_stimulus(0, 0);

    // seed=5, tick every cycle: count 5..0, time_out 6 cycles after capture.
    seed = 7'd5;
    push_ev(0, 5);
    push_ev(1, 6);
    apply_stimulus(1, 1);
    seed = 7'h55;
    check_output("run5_busy_rise", busy, 1);
    check_output("run5_count0", count_out, 5);
    for (int j = 1; j <= 5; j++) begin
      apply_stimulus(0, 1);
      check_output("run5_count", count_out, 5 - j);
    end
    apply_stimulus(0, 1);
    check_output("run5_time_out", time_out, 1);
    check_output("run5_busy_fall", busy, 0);

    // Floor to MIN_TICKS=3 for seed 0, then seed 2 triggered in the time_out cycle.
    seed = 7'd0;
    push_ev(0, 3);
    push_ev(1, 4);
    apply_stimulus(1, 1);
    for (int j = 0; j < 4; j++) apply_stimulus(0, 1);
    check_output("floor0_time_out", time_out, 1);
    seed = 7'd2;
    push_ev(0, 3);
    push_ev(1, 4);
    apply_stimulus(1, 1);
    check_output("floor2_count", count_out, 3);
    for (int j = 0; j < 4; j++) apply_stimulus(0, 1);
    apply_stimulus(0, 0);

    // seed=4, tick every 3rd cycle, re-trigger mid-COUNT ignored: 4th tick at edge 12.
    seed = 7'd4;
    push_ev(0, 4);
    push_ev(1, 13);
    apply_stimulus(1, 0);
    for (int j = 1; j <= 13; j++) begin
      apply_stimulus(j == 5, (j % 3) == 0);
      if (j == 4) check_output("slow_count_after_tick", count_out, 3);
      if (j == 5) check_output("slow_count_hold", count_out, 3);
    end
    apply_stimulus(0, 0);

    // Reset mid-COUNT at count_out=2: outputs clear at once, no time_out afterwards.
    seed = 7'd6;
    push_ev(0, 6);
    apply_stimulus(1, 1);
    for (int j = 0; j < 4; j++) apply_stimulus(0, 1);
    check_output("midrst_count_before", count_out, 2);
    #2;
    rst = 1'b0;
    #1;
    check_output("midrst_busy", busy, 0);
    check_output("midrst_count", count_out, 0);
    check_output("midrst_time_out", time_out, 0);
    check_output("midrst_lfsr_adv", lfsr_adv, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int j = 0; j < 8; j++) apply_stimulus(0, 1);
    check_output("midrst_idle_busy", busy, 0);
    seed = 7'd3;
    push_ev(0, 3);
    push_ev(1, 4);
    apply_stimulus(1, 1);
    for (int j = 0; j < 5; j++) apply_stimulus(0, 1);

`ifdef DELAY_ABORT_EN
    // Abort at count_out=3 wins over tick: back to IDLE with no time_out.
    seed = 7'd5;
    push_ev(0, 5);
    apply_stimulus(1, 1);
    apply_stimulus(0, 1);
    apply_stimulus(0, 1);
    check_output("abort_count_before", count_out, 3);
    abort = 1'b1;
    apply_stimulus(0, 1);
    abort = 1'b0;
    check_output("abort_count", count_out, 0);
    check_output("abort_busy", busy, 0);
    for (int j = 0; j < 6; j++) apply_stimulus(0, 1);
    check_output("abort_no_time_out", time_out, 0);
`endif

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) apply_stimulus(0, 1);
    check_output("events_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
